uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 868, meaning clk cycles per UART bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning byte-address width of the memory port.
REQ-003 SHALL have parameter BASE_ADDR, default 0, meaning the first byte address written after each load start.
REQ-004 SHALL have parameter WORD_MODE, default 1; 1 packs 4 bytes per write, 0 writes every byte as soon as it is received.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port Rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port prog  input  1  load enable; level-sensitive, synchronous to clk.
REQ-008 SHALL have port rx  input  1  UART serial data, 8N1, LSB first, idle high, asynchronous to clk.
REQ-009 SHALL have port mem_wea  output  1  write strobe to memory, one-cycle pulse.
REQ-010 SHALL have port mem_en  output  4  byte-lane enables for the write.
REQ-011 SHALL have port mem_addr  output  ADDR_W  word-aligned byte address in WORD_MODE=1; byte address in WORD_MODE=0.
REQ-012 SHALL have port mem_din  output  32  write data; byte k of the word on bits [8k+7:8k].
REQ-013 SHALL have port busy  output  1  high while prog is high or a flush is pending.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a load session completes.
REQ-015 SHALL have port frame_err  output  1  sticky; set on a bad stop bit, cleared at the next load start.
REQ-016 SHALL have port byte_cnt  output  ADDR_W+1  count of bytes accepted in the current or last session.

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer, reset value 1, before any use.
REQ-018 SHALL run the receiver FSM IDLE -> START -> DATA -> STOP -> IDLE, and only while prog=1.
REQ-019 SHALL, in IDLE, move to START on a synchronized falling edge (1->0) of rx.
REQ-020 SHALL, in START, re-sample at CLK_PER_BIT/2 cycles: if rx=0 go to DATA; if rx=1 treat it as a glitch and return to IDLE.
REQ-021 SHALL, in DATA, sample 8 bits, each CLK_PER_BIT cycles after the previous sample, LSB first.
REQ-022 SHALL, in STOP, sample once at CLK_PER_BIT: if rx=1 accept the byte; if rx=0 drop the byte, set frame_err and wait for rx=1 before IDLE.
REQ-023 SHALL, on the rising edge of prog, load the address counter with BASE_ADDR, clear byte_cnt, frame_err and the lane pointer, and raise busy on the next cycle.
REQ-024 SHALL, in WORD_MODE=1, place accepted byte n in lane n mod 4; when lane 3 fills, pulse mem_wea with mem_en=4'b1111, then advance the address by 4.
REQ-025 SHALL, in WORD_MODE=0, pulse mem_wea for each accepted byte with one-hot mem_en=1<<addr[1:0] and the byte replicated in all four lanes, then advance the address by 1.
REQ-026 SHALL assert mem_wea exactly one cycle after the byte is accepted; mem_en, mem_addr and mem_din are valid in that cycle and are 0 otherwise.
REQ-027 SHALL increment byte_cnt by 1 per accepted byte, saturating at all-ones.
REQ-028 SHALL wrap the address modulo 2^ADDR_W with no error flag.
REQ-029 SHALL, on the falling edge of prog: let a byte already in STOP complete and be accepted; abort any frame in START or DATA.
REQ-030 SHALL, after the actions in REQ-029 and in WORD_MODE=1, flush a partial word with one write whose mem_en covers only the filled lanes (e.g. 2 bytes -> 4'b0011).
REQ-031 SHALL pulse done one cycle after the final write, or one cycle after prog falls when nothing is pending, and drop busy in the same cycle.
REQ-032 SHALL, if prog rises again while a flush is pending, finish the flush and done first and start the new session on the following cycle.

Reset
REQ-033 SHALL, while Rst=0 and regardless of clk, drive every output to 0 except frame_err=0 and byte_cnt=0, put the FSM in IDLE and set the synchronizer to 1.
REQ-034 SHALL discard any partial frame or partial word when Rst asserts mid-session, with no write and no done pulse.

Verification (CLK_PER_BIT=4, ADDR_W=12, BASE_ADDR=0x100)
REQ-035 SHALL test WORD_MODE=1: prog=1, send 0x13,0x05,0x50,0x00 -> one mem_wea with addr 0x100, en 4'b1111, din 0x00500513; byte_cnt=4.
REQ-036 SHALL test WORD_MODE=1 partial flush: send 0xAA,0xBB, then drop prog -> write at addr 0x100 with en 4'b0011 and din[15:0]=0xBBAA, followed next cycle by done.
REQ-037 SHALL test WORD_MODE=0: send 0x11,0x22,0x33 -> three writes at 0x100/0x101/0x102 with en 0001/0010/0100.
REQ-038 SHALL test framing: send 0x5A with stop bit=0 -> no write, frame_err=1, byte_cnt=0; the next valid byte is still written.
REQ-039 SHALL test noise and idle: a 1-cycle low glitch on rx -> no write; rx traffic with prog=0 -> no write and busy=0.
REQ-040 SHALL test reset: assert Rst after 2 bytes of a word -> all outputs 0 immediately; a new session starts at 0x100.

Source files
------------

// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8N1 bytes while prog is high and writes them to a
// byte-addressed memory, packed four per word or one byte per write.
module uart_prog_loader #(
  parameter int unsigned       CLK_PER_BIT = 868,
  parameter int unsigned       ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter bit                WORD_MODE   = 1'b1
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              prog,
  input  logic              rx,
  output logic              mem_wea,
  output logic [3:0]        mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic [ADDR_W:0]   byte_cnt
);

  localparam logic [15:0]       HALF_M1 = 16'(CLK_PER_BIT / 2 - 1);
  localparam logic [15:0]       BIT_M1  = 16'(CLK_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_1  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_4  = ADDR_W'(4);
  localparam logic [ADDR_W:0]   CNT_1   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [1:0] {S_OFF, S_RUN, S_DRAIN, S_FLUSH} ses_state_t;

  rx_state_t  rx_state, rx_state_nxt;
  ses_state_t ses, ses_nxt;

  logic              rx_s1, rx_s2, rx_prev;
  logic [15:0]       cnt, cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shreg;
  logic              shift_en, ferr_set;
  logic              acc_vld_p0;
  logic [7:0]        acc_byte_p0;
  logic              start_ses, flush_req, done_set, closing;
  logic [1:0]        lane;
  logic [31:0]       word_buf;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_aligned;

  // Byte enables for the lanes already filled when a partial word is flushed.
  function automatic logic [3:0] lane_mask(input logic [1:0] filled);
    lane_mask = (4'b0001 << filled) - 4'b0001;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    lane_bits = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  assign acc_byte_p0  = shreg;
  assign addr_aligned = {addr[ADDR_W-1:2], 2'b00};
  assign busy         = (ses != S_OFF);

  // Stage: rx synchronizer and receiver state
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {rx_s2, shreg[7:1]};
  end

  always_comb begin
    rx_state_nxt = rx_state;
    cnt_nxt      = cnt + 16'd1;
    bit_idx_nxt  = bit_idx;
    shift_en     = 1'b0;
    ferr_set     = 1'b0;
    acc_vld_p0   = 1'b0;
    // A frame already in its stop bit is allowed to finish after prog drops.
    if (!prog && rx_state != RX_STOP) begin
      rx_state_nxt = RX_IDLE;
      cnt_nxt      = '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          cnt_nxt = '0;
          if (rx_prev && !rx_s2) rx_state_nxt = RX_START;
        end
        RX_START: if (cnt == HALF_M1) begin
          cnt_nxt      = '0;
          bit_idx_nxt  = '0;
          rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (cnt == BIT_M1) begin
          cnt_nxt     = '0;
          shift_en    = 1'b1;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
        end
        RX_STOP: if (cnt == BIT_M1) begin
          cnt_nxt = '0;
          if (rx_s2) begin
            acc_vld_p0   = 1'b1;
            rx_state_nxt = RX_IDLE;
          end else begin
            ferr_set     = 1'b1;
            rx_state_nxt = RX_WAIT;
          end
        end
        RX_WAIT: begin
          cnt_nxt = '0;
          if (rx_s2) rx_state_nxt = RX_IDLE;
        end
        default: rx_state_nxt = RX_IDLE;
      endcase
    end
  end

  // Session control: start, drain of a byte in flight, partial-word flush, done.
  always_comb begin
    ses_nxt   = ses;
    start_ses = 1'b0;
    flush_req = 1'b0;
    done_set  = 1'b0;
    closing   = (ses == S_RUN && !prog) || (ses == S_DRAIN);
    if (ses == S_OFF) begin
      if (prog) begin
        ses_nxt   = S_RUN;
        start_ses = 1'b1;
      end
    end else if (ses == S_FLUSH) begin
      done_set = 1'b1;
      ses_nxt  = S_OFF;
    end else if (closing) begin
      if (rx_state == RX_STOP) begin
        ses_nxt = S_DRAIN;
      end else if (WORD_MODE && lane != 2'd0) begin
        flush_req = 1'b1;
        ses_nxt   = S_FLUSH;
      end else begin
        done_set = 1'b1;
        ses_nxt  = S_OFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc_vld_p0 && WORD_MODE) word_buf[8*lane +: 8] <= acc_byte_p0;
  end

  // Stage: memory write port and session counters
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      ses       <= S_OFF;
      mem_wea   <= 1'b0;
      mem_en    <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      byte_cnt  <= '0;
      lane      <= '0;
      addr      <= '0;
    end else begin
      ses      <= ses_nxt;
      mem_wea  <= 1'b0;
      mem_en   <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      done     <= done_set;
      if (start_ses) begin
        addr      <= BASE_ADDR;
        byte_cnt  <= '0;
        frame_err <= 1'b0;
        lane      <= '0;
      end else begin
        if (ferr_set) frame_err <= 1'b1;
        if (acc_vld_p0 && ses != S_OFF) begin
          if (byte_cnt != '1) byte_cnt <= byte_cnt + CNT_1;
          if (WORD_MODE) begin
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              mem_wea  <= 1'b1;
              mem_en   <= 4'b1111;
              mem_addr <= addr_aligned;
              mem_din  <= {acc_byte_p0, word_buf[23:0]};
              addr     <= addr + ADDR_4;
            end
          end else begin
            mem_wea  <= 1'b1;
            mem_en   <= 4'b0001 << addr[1:0];
            mem_addr <= addr;
            mem_din  <= {4{acc_byte_p0}};
            addr     <= addr + ADDR_1;
          end
        end
        if (flush_req) begin
          mem_wea  <= 1'b1;
          mem_en   <= lane_mask(lane);
          mem_addr <= addr_aligned;
          mem_din  <= word_buf & lane_bits(lane_mask(lane));
          addr     <= addr + ADDR_4;
          lane     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: one word-mode and one byte-mode instance, randomized
// UART traffic, expected writes queued by a reference model and checked by a monitor.
module tb_uart_prog_loader;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Rst;
  logic        prog [2];
  logic        rx   [2];
  logic        wea  [2];
  logic [3:0]  en   [2];
  logic [11:0] addr [2];
  logic [31:0] din  [2];
  logic        busy [2];
  logic        done [2];
  logic        ferr [2];
  logic [12:0] bcnt [2];

  uart_prog_loader #(.CLK_PER_BIT(CPB), .ADDR_W(12), .BASE_ADDR(12'h100), .WORD_MODE(1'b1)) u_word (
    .clk(clk), .Rst(Rst), .prog(prog[0]), .rx(rx[0]), .mem_wea(wea[0]), .mem_en(en[0]),
    .mem_addr(addr[0]), .mem_din(din[0]), .busy(busy[0]), .done(done[0]),
    .frame_err(ferr[0]), .byte_cnt(bcnt[0]));

  uart_prog_loader #(.CLK_PER_BIT(CPB), .ADDR_W(12), .BASE_ADDR(12'h100), .WORD_MODE(1'b0)) u_byte (
    .clk(clk), .Rst(Rst), .prog(prog[1]), .rx(rx[1]), .mem_wea(wea[1]), .mem_en(en[1]),
    .mem_addr(addr[1]), .mem_din(din[1]), .busy(busy[1]), .done(done[1]),
    .frame_err(ferr[1]), .byte_cnt(bcnt[1]));

  typedef struct {
    bit          is_done;
    bit          follow;
    logic [11:0] addr;
    logic [3:0]  en;
    logic [31:0] din;
    logic [31:0] dmask;
  } exp_t;

  exp_t exp_q [2][$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_wr [2];

  // Reference model: per-instance session state.
  logic [11:0] m_addr [2];
  int          m_pend [2];
  logic [31:0] m_word [2];
  int          m_cnt  [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endfunction

  function automatic logic [31:0] bytes_mask(logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic void push_write(int d, logic [11:0] a, logic [3:0] e, logic [31:0] v,
                                     logic [31:0] dm);
    exp_t x;
    x.is_done = 1'b0; x.follow = 1'b0; x.addr = a; x.en = e; x.din = v; x.dmask = dm;
    exp_q[d].push_back(x);
  endfunction

  function automatic void push_done(int d, bit follow);
    exp_t x;
    x.is_done = 1'b1; x.follow = follow; x.addr = '0; x.en = '0; x.din = '0; x.dmask = '0;
    exp_q[d].push_back(x);
  endfunction

  function automatic void model_start(int d);
    m_addr[d] = 12'h100; m_pend[d] = 0; m_word[d] = '0; m_cnt[d] = 0;
  endfunction

  function automatic void model_accept(int d, logic [7:0] b);
    m_cnt[d]++;
    if (d == 0) begin
      m_word[d][8*m_pend[d] +: 8] = b;
      m_pend[d]++;
      if (m_pend[d] == 4) begin
        push_write(d, m_addr[d], 4'hF, m_word[d], 32'hFFFF_FFFF);
        m_addr[d] = m_addr[d] + 12'd4;
        m_pend[d] = 0;
        m_word[d] = '0;
      end
    end else begin
      push_write(d, m_addr[d], 4'(1 << m_addr[d][1:0]), {4{b}}, 32'hFFFF_FFFF);
      m_addr[d] = m_addr[d] + 12'd1;
    end
  endfunction

  function automatic void model_end(int d);
    logic [3:0] m;
    bit         fl;
    fl = (d == 0) && (m_pend[d] > 0);
    if (fl) begin
      m = 4'((1 << m_pend[d]) - 1);
      push_write(d, {m_addr[d][11:2], 2'b00}, m, m_word[d], bytes_mask(m));
    end
    push_done(d, fl);
    m_pend[d] = 0;
  endfunction

  // Monitor: every write or done the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (wea[d] === 1'b1) begin
        check("write_expected", 64'(exp_q[d].size() > 0), 64'd1);
        if (exp_q[d].size() > 0) begin
          e = exp_q[d].pop_front();
          check("write_kind", 64'(e.is_done), 64'd0);
          check("write_addr", 64'(addr[d]), 64'(e.addr));
          check("write_en", 64'(en[d]), 64'(e.en));
          check("write_din", 64'(din[d] & e.dmask), 64'(e.din & e.dmask));
        end
        last_wr[d] = cyc;
      end
      if (done[d] === 1'b1) begin
        check("done_expected", 64'(exp_q[d].size() > 0), 64'd1);
        if (exp_q[d].size() > 0) begin
          e = exp_q[d].pop_front();
          check("done_kind", 64'(e.is_done), 64'd1);
          if (e.follow) check("done_after_flush", 64'(cyc), 64'(last_wr[d] + 1));
          check("done_busy_low", 64'(busy[d]), 64'd0);
        end
      end
    end
  end

  task automatic send_byte(int d, logic [7:0] b, bit stop_ok);
    @(negedge clk);
    if (stop_ok && prog[d]) model_accept(d, b);
    rx[d] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx[d] = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx[d] = stop_ok;
    repeat (CPB) @(negedge clk);
    rx[d] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic start_session(int d);
    @(negedge clk);
    prog[d] = 1'b1;
    model_start(d);
    repeat (3) @(negedge clk);
    check("busy_on", 64'(busy[d]), 64'd1);
  endtask

  task automatic end_session(int d);
    int t;
    @(negedge clk);
    model_end(d);
    prog[d] = 1'b0;
    t = 0;
    while (exp_q[d].size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 64'(exp_q[d].size()), 64'd0);
    repeat (2) @(negedge clk);
    check("busy_off", 64'(busy[d]), 64'd0);
  endtask

  task automatic check_zero(int d, string tag);
    check({tag, "_wr"}, {15'd0, wea[d], en[d], addr[d], din[d]}, 64'd0);
    check({tag, "_ctl"}, {48'd0, busy[d], done[d], ferr[d], bcnt[d]}, 64'd0);
  endtask

  initial begin
    Rst = 1'b0;
    prog[0] = 1'b0; prog[1] = 1'b0;
    rx[0] = 1'b1;   rx[1] = 1'b1;
    last_wr[0] = -10; last_wr[1] = -10;
    #3;
    check_zero(0, "rst0");
    check_zero(1, "rst1");
    repeat (3) @(negedge clk);
    Rst = 1'b1;

    // Full word: 0x00500513 at 0x100.
    start_session(0);
    send_byte(0, 8'h13, 1'b1);
    send_byte(0, 8'h05, 1'b1);
    send_byte(0, 8'h50, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    check("word_bcnt", 64'(bcnt[0]), 64'd4);
    end_session(0);

    // Partial word flushed when prog drops.
    start_session(0);
    send_byte(0, 8'hAA, 1'b1);
    send_byte(0, 8'hBB, 1'b1);
    check("flush_bcnt", 64'(bcnt[0]), 64'd2);
    end_session(0);

    // Byte mode: three single-lane writes.
    start_session(1);
    send_byte(1, 8'h11, 1'b1);
    send_byte(1, 8'h22, 1'b1);
    send_byte(1, 8'h33, 1'b1);
    check("byte_bcnt", 64'(bcnt[1]), 64'd3);
    end_session(1);

    // Bad stop bit, then a good byte.
    start_session(0);
    send_byte(0, 8'h5A, 1'b0);
    check("ferr_set", 64'(ferr[0]), 64'd1);
    check("ferr_bcnt", 64'(bcnt[0]), 64'd0);
    send_byte(0, 8'h77, 1'b1);
    check("ferr_sticky", 64'(ferr[0]), 64'd1);
    check("ferr_next_bcnt", 64'(bcnt[0]), 64'd1);
    end_session(0);

    // Glitch, then traffic with prog low.
    start_session(0);
    check("ferr_cleared", 64'(ferr[0]), 64'd0);
    @(negedge clk); rx[0] = 1'b0;
    @(negedge clk); rx[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_bcnt", 64'(bcnt[0]), 64'd0);
    end_session(0);
    send_byte(0, 8'hC3, 1'b1);
    check("idle_busy", 64'(busy[0]), 64'd0);

    // Asynchronous reset in the middle of a word.
    start_session(0);
    send_byte(0, 8'hDE, 1'b1);
    send_byte(0, 8'hAD, 1'b1);
    check("pre_reset_bcnt", 64'(bcnt[0]), 64'd2);
    @(negedge clk);
    #2 Rst = 1'b0;
    #1 check_zero(0, "midrst");
    prog[0] = 1'b0;
    m_pend[0] = 0;
    repeat (3) @(negedge clk);
    Rst = 1'b1;
    start_session(0);
    for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom_range(0, 255)), 1'b1);
    end_session(0);

    // Randomized sessions on both instances.
    for (int s = 0; s < 6; s++) begin
      int d, n;
      d = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 9));
      start_session(d);
      for (int i = 0; i < n; i++) send_byte(d, 8'($urandom_range(0, 255)), 1'b1);
      check("rand_bcnt", 64'(bcnt[d]), 64'(m_cnt[d]));
      end_session(d);
    end

    repeat (5) @(negedge clk);
    check("queue0_empty", 64'(exp_q[0].size()), 64'd0);
    check("queue1_empty", 64'(exp_q[1].size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
